// File: rtl/hs_pkg.sv
// Shared types for the handshake traffic generator: pattern modes, FSM states, LFSR default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_DECR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] HS_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/hs_pattern_gen.sv
// Beat payload register: loads the seed, then steps INCR/DECR/LFSR/CONST on each advance.
// Latency: new value visible the cycle after load/advance.
// Backpressure: holds its value whenever advance is low.
module hs_pattern_gen
    import hs_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = DATA_W'(HS_LFSR_TAPS)
) (
    input  logic              clk_1,
    input  logic              reset_1,
    input  logic              load_1,
    input  logic              advance_1,
    input  logic [1:0]        mode_1,
    input  logic [DATA_W-1:0] seed_1,
    output logic [DATA_W-1:0] data_1
);

    mode_e             mode_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] next_val;

    always_comb begin
        next_val = data_q;
        unique case (mode_q)
            MODE_INCR:  next_val = data_q + DATA_W'(1);
            MODE_DECR:  next_val = data_q - DATA_W'(1);
            MODE_LFSR:  next_val = data_q[0] ? ((data_q >> 1) ^ LFSR_TAPS) : (data_q >> 1);
            MODE_CONST: next_val = data_q;
            default:    next_val = data_q;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (reset_1) begin
            mode_q <= MODE_INCR;
            data_q <= '0;
        end else if (load_1) begin
            mode_q <= mode_e'(mode_1);
            // An all-zero LFSR state would never leave zero.
            if (mode_e'(mode_1) == MODE_LFSR && seed_1 == '0)
                data_q <= DATA_W'(1);
            else
                data_q <= seed_1;
        end else if (advance_1) begin
            data_q <= next_val;
        end
    end

    assign data_1 = data_q;

endmodule

// File: rtl/hs_traffic_gen.sv
// Burst traffic generator with valid/ready output; optional parity_1 under HS_TRAFFIC_GEN_PARITY_EN.
// Latency: first beat valid 1 cycle after start_1; done_1 1 cycle after the final transfer.
// Backpressure: valid_1/data_1 held stable until ready_1; abort_1 never withdraws a presented beat.
module hs_traffic_gen
    import hs_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 LEN_W     = 8,
    parameter int                 GAP_W     = 4,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = DATA_W'(HS_LFSR_TAPS)
) (
    input  logic              clk_1,
    input  logic              reset_1,
    input  logic              start_1,
    input  logic [1:0]        mode_1,
    input  logic [DATA_W-1:0] seed_1,
    input  logic [LEN_W-1:0]  burst_len_1,
    input  logic [GAP_W-1:0]  gap_1,
    input  logic              abort_1,
    input  logic              ready_1,
    output logic              valid_1,
    output logic [DATA_W-1:0] data_1,
    output logic              busy_1,
    output logic              done_1,
    output logic              aborted_1,
    output logic [LEN_W-1:0]  beat_cnt_1
`ifdef HS_TRAFFIC_GEN_PARITY_EN
    ,
    output logic              parity_1
`endif
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             abort_flag_q;
    logic             aborted_q;

    logic             xfer;
    logic             last_beat;
    logic             abort_eff;
    logic             load;
    logic             advance;
    logic             set_aborted;

    assign valid_1   = (state_q == ST_SEND);
    assign xfer      = valid_1 && ready_1;
    // Extra bit keeps the compare correct for the maximum length.
    assign last_beat = ({1'b0, beat_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q};
    assign abort_eff = abort_flag_q || abort_1;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        advance     = 1'b0;
        set_aborted = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_1) begin
                    load    = 1'b1;
                    state_d = (burst_len_1 != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else if (abort_eff) begin
                        state_d     = ST_DONE;
                        set_aborted = 1'b1;
                    end else begin
                        advance = 1'b1;
                        state_d = (gap_q != '0) ? ST_GAP : ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (abort_eff) begin
                    state_d     = ST_DONE;
                    set_aborted = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (reset_1) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            abort_flag_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                len_q        <= burst_len_1;
                gap_q        <= gap_1;
                beat_cnt_q   <= '0;
                abort_flag_q <= 1'b0;
                aborted_q    <= 1'b0;
            end else if (state_q != ST_IDLE && abort_1) begin
                abort_flag_q <= 1'b1;
            end
            if (xfer)
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (set_aborted)
                aborted_q <= 1'b1;
            if (state_q == ST_SEND && state_d == ST_GAP)
                gap_cnt_q <= gap_q;
            else if (state_q == ST_GAP)
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
    end

    hs_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern_gen (
        .clk_1     (clk_1),
        .reset_1   (reset_1),
        .load_1    (load),
        .advance_1 (advance),
        .mode_1    (mode_1),
        .seed_1    (seed_1),
        .data_1    (data_1)
    );

    assign busy_1     = (state_q != ST_IDLE);
    assign done_1     = (state_q == ST_DONE);
    assign aborted_1  = aborted_q;
    assign beat_cnt_1 = beat_cnt_q;

`ifdef HS_TRAFFIC_GEN_PARITY_EN
    assign parity_1 = ^data_1;
`endif

endmodule
